// File: rtl/core_seq_ctrl_pkg.sv
// Shared constants, state/phase types and phase lengths for the core sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_ctrl_pkg;

    // Array and workload geometry
    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int IN_W    = 6;
    localparam int K       = 3;
    localparam int WBASE   = 1024;
    localparam int GAP     = 10;
    localparam int RST_CYC = 10;
    localparam int OUT_LAT = 2;

    localparam int LEN_NIJ = IN_W * IN_W;
    localparam int LEN_KIJ = K * K;
    localparam int OUT_W   = IN_W - K + 1;
    localparam int N_OUT   = OUT_W * OUT_W;

    localparam int INST_W  = 35;
    localparam int ADDR_W  = 11;
    localparam int CNT_W   = 6;
    localparam int IDX_W   = 4;

    // inst bit positions
    localparam int B_MODE     = 34;
    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_HI    = 30;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_HI    = 17;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // All SRAM enables/write-enables deasserted, mode bit zero.
    localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

    // Counter-width versions of the lengths used in cycle-window compares
    localparam logic [CNT_W-1:0] C_COL = CNT_W'(COL);
    localparam logic [CNT_W-1:0] C_NIJ = CNT_W'(LEN_NIJ);
    localparam logic [CNT_W-1:0] C_KIJ = CNT_W'(LEN_KIJ);
    localparam logic [IDX_W-1:0] KIJ_LAST = IDX_W'(LEN_KIJ - 1);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(N_OUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_KRST, S_W_L0, S_G1, S_LOAD, S_G2, S_A_L0, S_G3,
        S_EXEC, S_OWAIT, S_ORD, S_G4, S_ACLR, S_AREAD, S_AHOLD, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_NONE, PH_ORD, PH_AREAD
    } addr_ph_e;

    // Counter value on which a timed state exits (length - 1).
    function automatic logic [CNT_W-1:0] phase_last(input state_e s);
        logic [CNT_W-1:0] v;
        unique case (s)
            S_KRST:                   v = CNT_W'(RST_CYC - 1);
            S_W_L0, S_LOAD:           v = CNT_W'(COL);
            S_G1, S_G2, S_G3, S_G4:   v = CNT_W'(GAP - 1);
            S_A_L0, S_ORD:            v = CNT_W'(LEN_NIJ);
            S_EXEC:                   v = CNT_W'(LEN_NIJ + ROW + COL - 1);
            S_AREAD:                  v = CNT_W'(LEN_KIJ);
            S_AHOLD:                  v = CNT_W'(OUT_LAT - 1);
            default:                  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Host/core-facing signal bundle of the sequencer.
// Latency: n/a (wires only).
// Backpressure: ofifo_valid stalls the sequencer in OWAIT; start is dropped while busy.
// master: the sequencer (drives inst/status); slave: host + core side.
interface core_seq_ctrl_if
    import core_ctrl_pkg::*;
;
    logic              start;
    logic              mode_in;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        input  start, mode_in, ofifo_valid,
        output inst, core_rst, busy, done, out_valid, out_idx
    );

    modport slave (
        output start, mode_in, ofifo_valid,
        input  inst, core_rst, busy, done, out_valid, out_idx
    );
endinterface

// File: rtl/core_seq_ctrl_addr_gen.sv
// pmem address generator for the OFIFO drain and the per-pixel accumulation reads.
// Latency: address is combinational from the current phase; pixel/tap counters are registered.
// Backpressure: none; steps only when the sequencer says so.
// Ports: i_clk/i_reset, i_kij, i_cnt (phase cycle), i_phase, i_pix_clr/i_pix_step, o_a_pmem.
module conv_addr_gen
    import core_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [IDX_W-1:0]  i_kij,
    input  logic [CNT_W-1:0]  i_cnt,
    input  addr_ph_e          i_phase,
    input  logic              i_pix_clr,
    input  logic              i_pix_step,
    output logic [ADDR_W-1:0] o_a_pmem
);
    localparam logic [IDX_W-1:0] OX_LAST = IDX_W'(OUT_W - 1);
    localparam logic [IDX_W-1:0] KC_LAST = IDX_W'(K - 1);

    // Output pixel (ox, oy) and kernel tap (kc, kr) tracked as row/column
    // counters so no divide/modulo by K or OUT_W is ever built.
    logic [IDX_W-1:0]  r_ox, r_oy, r_kc, r_kr;
    logic [ADDR_W-1:0] r_kbase;      // k * len_nij

    logic [IDX_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_ord_addr, w_acc_addr;

    always_comb begin
        w_row      = r_oy + r_kr;
        // ORD cycle i writes psum i-1 of this kij
        w_ord_addr = ADDR_W'(32'(i_kij) * LEN_NIJ) + ADDR_W'(i_cnt) - ADDR_W'(1);
        w_acc_addr = r_kbase + ADDR_W'(32'(w_row) * IN_W) + ADDR_W'(r_ox) + ADDR_W'(r_kc);
        unique case (i_phase)
            PH_ORD:   o_a_pmem = w_ord_addr;
            PH_AREAD: o_a_pmem = w_acc_addr;
            default:  o_a_pmem = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ox    <= '0;
            r_oy    <= '0;
            r_kc    <= '0;
            r_kr    <= '0;
            r_kbase <= '0;
        end else begin
            // Tap counters run only across the read window and rewind otherwise,
            // so each AREAD starts at tap 0.
            if (i_phase == PH_AREAD) begin
                r_kbase <= r_kbase + ADDR_W'(LEN_NIJ);
                if (r_kc == KC_LAST) begin
                    r_kc <= '0;
                    r_kr <= r_kr + 1'b1;
                end else begin
                    r_kc <= r_kc + 1'b1;
                end
            end else begin
                r_kc    <= '0;
                r_kr    <= '0;
                r_kbase <= '0;
            end

            if (i_pix_clr) begin
                r_ox <= '0;
                r_oy <= '0;
            end else if (i_pix_step) begin
                if (r_ox == OX_LAST) begin
                    r_ox <= '0;
                    r_oy <= r_oy + 1'b1;
                end else begin
                    r_ox <= r_ox + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/core_seq_ctrl.sv
// Sequencer generating the 35-bit core inst word for the whole conv + accumulation flow.
// Latency: every output is registered; one cycle after the state/counter that produces it.
// Backpressure: waits in OWAIT for ofifo_valid; start is ignored unless idle.
// Ports: clk, reset (sync, active-high), bus (master: start/mode_in/ofifo_valid in;
//        inst/core_rst/busy/done/out_valid/out_idx out).
module core_seq_ctrl
    import core_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    core_seq_ctrl_if.master bus
);
    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_kij, w_kij_nxt;
    logic [IDX_W-1:0]  r_onij, w_onij_nxt;
    logic              r_mode, w_mode_nxt;

    logic [INST_W-1:0] r_inst, w_inst_nxt;
    logic              r_core_rst, w_core_rst_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [IDX_W-1:0]  r_out_idx, w_out_idx_nxt;

    logic              w_tc;
    addr_ph_e          w_phase;
    logic              w_pix_clr, w_pix_step;
    logic [ADDR_W-1:0] w_a_pmem;
    logic [ADDR_W-1:0] w_a_xmem;

    assign w_tc = (r_cnt == phase_last(r_state));

    conv_addr_gen u_addr (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_kij      (r_kij),
        .i_cnt      (r_cnt),
        .i_phase    (w_phase),
        .i_pix_clr  (w_pix_clr),
        .i_pix_step (w_pix_step),
        .o_a_pmem   (w_a_pmem)
    );

    // Next-state and counters
    always_comb begin
        w_state_nxt = r_state;
        w_kij_nxt   = r_kij;
        w_onij_nxt  = r_onij;
        w_mode_nxt  = r_mode;
        w_pix_clr   = 1'b0;
        w_pix_step  = 1'b0;

        unique case (r_state)
            S_IDLE: if (bus.start) begin
                w_state_nxt = S_KRST;
                w_mode_nxt  = bus.mode_in;
                w_kij_nxt   = '0;
                w_onij_nxt  = '0;
                w_pix_clr   = 1'b1;
            end
            S_KRST:  if (w_tc) w_state_nxt = S_W_L0;
            S_W_L0:  if (w_tc) w_state_nxt = S_G1;
            S_G1:    if (w_tc) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_tc) w_state_nxt = S_G2;
            S_G2:    if (w_tc) w_state_nxt = S_A_L0;
            S_A_L0:  if (w_tc) w_state_nxt = S_G3;
            S_G3:    if (w_tc) w_state_nxt = S_EXEC;
            S_EXEC:  if (w_tc) w_state_nxt = S_OWAIT;
            S_OWAIT: if (bus.ofifo_valid) w_state_nxt = S_ORD;
            S_ORD:   if (w_tc) w_state_nxt = S_G4;
            S_G4: if (w_tc) begin
                if (r_kij == KIJ_LAST) begin
                    w_state_nxt = S_ACLR;
                    w_onij_nxt  = '0;
                end else begin
                    w_state_nxt = S_KRST;
                    w_kij_nxt   = r_kij + 1'b1;
                end
            end
            S_ACLR:  if (w_tc) w_state_nxt = S_AREAD;
            S_AREAD: if (w_tc) w_state_nxt = S_AHOLD;
            S_AHOLD: if (w_tc) begin
                if (r_onij == OUT_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ACLR;
                    w_onij_nxt  = r_onij + 1'b1;
                    w_pix_step  = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Counter restarts on every state change; untimed waits hold it at 0.
        if (w_state_nxt != r_state || r_state == S_IDLE || r_state == S_OWAIT)
            w_cnt_nxt = '0;
        else
            w_cnt_nxt = r_cnt + 1'b1;
    end

    // Output decode for the current state/cycle; registered below.
    always_comb begin
        w_inst_nxt         = IDLE_INST;
        w_inst_nxt[B_MODE] = r_mode;
        w_core_rst_nxt     = 1'b0;
        w_done_nxt         = 1'b0;
        w_out_valid_nxt    = 1'b0;
        w_out_idx_nxt      = r_out_idx;
        w_busy_nxt         = (r_state != S_IDLE) && (r_state != S_DONE);
        w_phase            = PH_NONE;
        w_a_xmem           = '0;

        unique case (r_state)
            S_KRST, S_ACLR: w_core_rst_nxt = 1'b1;
            S_W_L0, S_A_L0: begin
                // SRAM read on cycles 0..n-1, L0 write lags by one for read latency
                w_a_xmem = (r_state == S_W_L0)
                         ? ADDR_W'(WBASE + 32'(r_kij) * COL + 32'(r_cnt))
                         : ADDR_W'(r_cnt);
                if (r_cnt < ((r_state == S_W_L0) ? C_COL : C_NIJ)) begin
                    w_inst_nxt[B_CEN_X]         = 1'b0;
                    w_inst_nxt[B_AX_HI:B_AX_LO] = w_a_xmem;
                end
                if (r_cnt != '0) w_inst_nxt[B_L0_WR] = 1'b1;
            end
            S_LOAD: begin
                if (r_cnt < C_COL) w_inst_nxt[B_L0_RD] = 1'b1;
                if (r_cnt != '0)   w_inst_nxt[B_LOAD]  = 1'b1;
            end
            S_EXEC: begin
                w_inst_nxt[B_EXEC] = 1'b1;
                if (r_cnt < C_NIJ) w_inst_nxt[B_L0_RD] = 1'b1;
            end
            S_ORD: begin
                if (r_cnt < C_NIJ) w_inst_nxt[B_OFIFO_RD] = 1'b1;
                if (r_cnt != '0) begin
                    w_phase             = PH_ORD;
                    w_inst_nxt[B_CEN_P] = 1'b0;
                    w_inst_nxt[B_WEN_P] = 1'b0;
                end
            end
            S_AREAD: begin
                if (r_cnt < C_KIJ) begin
                    w_phase             = PH_AREAD;
                    w_inst_nxt[B_CEN_P] = 1'b0;
                end
                if (r_cnt != '0) w_inst_nxt[B_ACC] = 1'b1;
            end
            S_AHOLD: if (w_tc) begin
                w_out_valid_nxt = 1'b1;
                w_out_idx_nxt   = r_onij;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase

        w_inst_nxt[B_AP_HI:B_AP_LO] = w_a_pmem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_kij       <= '0;
            r_onij      <= '0;
            r_mode      <= 1'b0;
            r_inst      <= IDLE_INST;
            r_core_rst  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_kij       <= w_kij_nxt;
            r_onij      <= w_onij_nxt;
            r_mode      <= w_mode_nxt;
            r_inst      <= w_inst_nxt;
            r_core_rst  <= w_core_rst_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_idx   <= w_out_idx_nxt;
        end
    end

    assign bus.inst      = r_inst;
    assign bus.core_rst  = r_core_rst;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: expected xmem/pmem addresses and pixel indices
// are queued when a run is launched; a forked monitor pops and compares on DUT activity.
module tb_core_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    core_seq_ctrl_if bus();
    core_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [34:0] IDLE0 = 35'h1_800C_0000;
    localparam logic [34:0] IDLE1 = 35'h5_800C_0000;

    int n_checks = 0;
    int n_errors = 0;
    bit sb_on = 0;
    bit exp_mode = 0;
    int xq[$];
    int pwq[$];
    int prq[$];
    int oq[$];
    int c_l0wr, c_load, c_exrd, c_exec, c_ordrd, c_acc, c_done, c_crst, c_badmode, c_ififo;

    int acc0[9]  = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
    int acc15[9] = '{21, 58, 95, 135, 172, 209, 249, 286, 323};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_cmp(input string name, input bit empty, input longint act, input longint exp);
        n_checks++;
        if (empty) begin
            n_errors++;
            $display("FAIL %s: unexpected value %0d, nothing expected", name, act);
        end else if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        bit empty;
        int e;
        forever begin
            @(negedge clk);
            if (sb_on && !reset) begin
                if (!bus.inst[19]) begin
                    empty = (xq.size() == 0);
                    e = empty ? 0 : xq.pop_front();
                    sb_cmp("A_xmem", empty, bus.inst[17:7], e);
                end
                if (!bus.inst[32] && !bus.inst[31]) begin
                    empty = (pwq.size() == 0);
                    e = empty ? 0 : pwq.pop_front();
                    sb_cmp("pmem_wr_addr", empty, bus.inst[30:20], e);
                end
                if (!bus.inst[32] && bus.inst[31]) begin
                    empty = (prq.size() == 0);
                    e = empty ? 0 : prq.pop_front();
                    sb_cmp("pmem_rd_addr", empty, bus.inst[30:20], e);
                end
                if (bus.out_valid) begin
                    empty = (oq.size() == 0);
                    e = empty ? 0 : oq.pop_front();
                    sb_cmp("out_idx", empty, bus.out_idx, e);
                end
                c_l0wr  += int'(bus.inst[2]);
                c_load  += int'(bus.inst[0]);
                c_exrd  += int'(bus.inst[1] & bus.inst[3]);
                c_exec  += int'(bus.inst[1]);
                c_ordrd += int'(bus.inst[6]);
                c_acc   += int'(bus.inst[33]);
                c_done  += int'(bus.done);
                c_crst  += int'(bus.core_rst);
                if (bus.busy && (bus.inst[34] != exp_mode)) c_badmode++;
                if (bus.inst[5] || bus.inst[4]) c_ififo++;
            end
        end
    endtask

    task automatic push_run();
        for (int kij = 0; kij < 9; kij++) begin
            for (int i = 0; i < 8; i++)  xq.push_back(1024 + kij * 8 + i);
            for (int i = 0; i < 36; i++) xq.push_back(i);
            for (int i = 0; i < 36; i++) pwq.push_back(kij * 36 + i);
        end
        for (int o = 0; o < 16; o++) begin
            oq.push_back(o);
            for (int k = 0; k < 9; k++) begin
                if (o == 0)       prq.push_back(acc0[k]);
                else if (o == 15) prq.push_back(acc15[k]);
                else              prq.push_back(k * 36 + (o / 4 + k / 3) * 6 + o % 4 + k % 3);
            end
        end
    endtask

    task automatic run_full(input bit m, input bit poke);
        bit got, poked;
        c_l0wr = 0; c_load = 0; c_exrd = 0; c_exec = 0; c_ordrd = 0;
        c_acc = 0; c_done = 0; c_crst = 0; c_badmode = 0; c_ififo = 0;
        xq.delete(); pwq.delete(); prq.delete(); oq.delete();
        exp_mode = m;
        push_run();
        sb_on = 1;
        @(negedge clk);
        bus.mode_in = m;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.mode_in = ~m;
        got = 0;
        poked = 0;
        for (int cyc = 0; cyc < 6000 && !got; cyc++) begin
            @(negedge clk);
            if (bus.done) got = 1;
            if (poke && !poked && bus.inst[1] && c_exec > 20) begin
                bus.start = 1'b1;
                poked = 1;
                @(negedge clk);
                bus.start = 1'b0;
                if (bus.done) got = 1;
            end
        end
        check("run_done_seen", got, 1);
        repeat (3) @(negedge clk);
        sb_on = 0;
        check("xmem_queue_left", xq.size(), 0);
        check("pmem_wr_queue_left", pwq.size(), 0);
        check("pmem_rd_queue_left", prq.size(), 0);
        check("out_queue_left", oq.size(), 0);
        check("l0_wr_cycles", c_l0wr, 396);
        check("load_cycles", c_load, 72);
        check("exec_l0rd_cycles", c_exrd, 324);
        check("exec_cycles", c_exec, 468);
        check("ofifo_rd_cycles", c_ordrd, 324);
        check("acc_cycles", c_acc, 144);
        check("done_pulses", c_done, 1);
        check("core_rst_cycles", c_crst, 106);
        check("mode_bit_errors", c_badmode, 0);
        check("ififo_cycles", c_ififo, 0);
        check("idle_inst_after_run", bus.inst, m ? IDLE1 : IDLE0);
        check("busy_after_run", bus.busy, 0);
    endtask

    initial begin
        bit got, prev;
        int bad, ordseen, lat, rises;
        bus.start = 1'b0;
        bus.mode_in = 1'b0;
        bus.ofifo_valid = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_inst", bus.inst, IDLE0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_core_rst", bus.core_rst, 0);
        check("reset_out_valid", bus.out_valid, 0);

        // Full OS-mode run with a stray start during EXEC
        run_full(1'b1, 1'b1);

        // OWAIT stall, then reset in the middle of kij 4's EXEC
        bus.ofifo_valid = 1'b0;
        @(negedge clk);
        bus.mode_in = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 500 && !got; cyc++) begin
            @(negedge clk);
            if (bus.inst[1]) got = 1;
        end
        check("reach_exec_kij0", got, 1);
        got = 0;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            @(negedge clk);
            if (!bus.inst[1]) got = 1;
        end
        check("exec_kij0_ends", got, 1);
        bad = 0;
        ordseen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.inst !== IDLE1) bad++;
            if (bus.inst[6]) ordseen++;
        end
        check("owait_inst_idle", bad, 0);
        check("owait_no_ofifo_rd", ordseen, 0);
        bus.ofifo_valid = 1'b1;
        lat = 0;
        while (!bus.inst[6] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("ord_start_latency", lat, 2);

        rises = 1;
        prev = bus.inst[1];
        for (int cyc = 0; cyc < 3000 && rises < 5; cyc++) begin
            @(negedge clk);
            if (bus.inst[1] && !prev) rises++;
            prev = bus.inst[1];
        end
        check("reach_exec_kij4", rises, 5);
        repeat (10) @(negedge clk);
        check("exec_kij4_active", bus.inst[1], 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_inst", bus.inst, IDLE0);
        check("midrun_reset_core_rst", bus.core_rst, 0);
        check("midrun_reset_busy", bus.busy, 0);
        check("midrun_reset_done", bus.done, 0);
        check("midrun_reset_out_valid", bus.out_valid, 0);
        check("midrun_reset_out_idx", bus.out_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fresh WS-mode run restarts at kij 0
        run_full(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Hardware sequencer that replaces bench-driven stimulus for `core`.
- Emits the 35-bit `inst` word that drives the whole convolution flow, per kernel position (kij):
  - kernel xmem→L0 transfer,
  - kernel load into the PEs,
  - activation xmem→L0 transfer,
  - execute,
  - OFIFO→pmem drain.
- After all kij it runs per-output-pixel accumulation: reads pmem and asserts `acc`.
- Sits between the host/top-level start logic and the `core` `inst` input. `inst` is registered, so no external pipeline stage is needed.

Parameters:
- row, 8, PE array rows
- col, 8, PE array columns (also the number of kernel words per kij)
- IN_W, 6, input feature-map width (len_nij = IN_W*IN_W = 36)
- K, 3, kernel width (len_kij = K*K = 9)
- WBASE, 1024, xmem base address of the kernel region; kernel kij lives at WBASE + kij*col
- GAP, 10, idle cycles between phases
- RST_CYC, 10, cycles `core_rst` is held at the start of each kij pass
- OUT_LAT, 2, cycles from the last `acc` cycle to `out_valid`

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse that begins a full run; ignored unless in IDLE
- mode_in  in  1  WS(0)/OS(1) select, latched on accepted start
- ofifo_valid  in  1  `core` OFIFO has data
- inst  out  35  `core` instruction word, registered
- core_rst  out  1  reset request to `core`/SFP (OR'd with the system reset at top level)
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle pulse when the run completes
- out_valid  out  1  one-cycle strobe: `core` output for pixel `out_idx` is valid
- out_idx  out  4  output pixel index onij = oy*OUT_W+ox, where OUT_W = IN_W-K+1

Behaviour:
- inst fields:
  - [34] mode
  - [33] acc
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- IDLE_INST = 35'h1_800C_0000: CEN/WEN = 1, everything else 0, mode = latched mode.
- Reset (any state, mid-run included):
  - state=IDLE, inst=IDLE_INST with mode=0
  - core_rst=0, busy=0, done=0, out_valid=0, counters=0, kij=0
- ififo_wr and ififo_rd are always 0.
- FSM per kij (kij 0..len_kij-1); each state exits on its counter's terminal count. Phases run in this order:
  - KRST (RST_CYC cycles): core_rst=1.
  - W_L0 (col+1 cycles):
    - CEN_xmem=0, WEN_xmem=1 and A_xmem=WBASE+kij*col+i on cycles 0..col-1.
    - l0_wr=1 on cycles 1..col (1-cycle SRAM latency).
  - G1 (GAP cycles): idle.
  - LOAD (col+1 cycles): l0_rd=1 on cycles 0..col-1; load=1 on cycles 1..col.
  - G2 (GAP cycles): idle.
  - A_L0 (len_nij+1 cycles): same pattern as W_L0 with A_xmem=i.
  - G3 (GAP cycles): idle.
  - EXEC (len_nij+row+col cycles): execute=1 throughout; l0_rd=1 on the first len_nij cycles.
  - OWAIT: hold IDLE_INST until ofifo_valid=1. No timeout. Reset is the only exit other than valid.
  - ORD (len_nij+1 cycles):
    - ofifo_rd=1 on cycles 0..len_nij-1.
    - CEN_pmem=0, WEN_pmem=0 and A_pmem=kij*len_nij+(i-1) on cycles 1..len_nij.
  - G4 (GAP cycles): then kij+1 → KRST, or after kij = len_kij-1 → ACC.
- ACC per onij o = 0..OUT_W²-1, with oy=o/OUT_W, ox=o%OUT_W:
  - ACLR (1 cycle): core_rst=1.
  - AREAD (len_kij+1 cycles):
    - CEN_pmem=0, WEN_pmem=1 on cycles 0..len_kij-1.
    - A_pmem = k*len_nij + (oy+k/K)*IN_W + ox + k%K on those cycles.
    - acc=1 on cycles 1..len_kij.
  - AHOLD (OUT_LAT cycles): then out_valid=1 for one cycle, out_idx=o.
  - After the last o: DONE.
- DONE: done=1 for one cycle, busy drops the same cycle, → IDLE.
- start while busy: ignored, no effect on the state or counters.
- Address widths:
  - A_pmem max = len_kij*len_nij-1 = 323, fits 11 bits.
  - A_xmem max = WBASE+len_kij*col-1 = 1095, fits 11 bits.
  - Arithmetic is unsigned and truncated to 11 bits; legal parameter sets never wrap.

Decomposition:
- Package core_ctrl_pkg:
  - state enum
  - inst bit-position constants
  - IDLE_INST
  - derived localparams len_nij, len_kij, OUT_W
- Sub-module conv_addr_gen (combinational plus one register stage):
  - inputs: kij, onij, phase
  - output: A_pmem
  - removes the divide/modulo by K and OUT_W via row/column counters.

Test Plan:
- Reset held 3 cycles, then released with no start → inst=35'h1_800C_0000, busy=0, done=0, core_rst=0.
- start with mode_in=1, ofifo_valid tied 1 → in every kij, exactly:
  - 8 l0_wr cycles in W_L0, with A_xmem 1024+8*kij..+7;
  - 8 load cycles;
  - 36 execute-with-l0_rd cycles;
  - 36 pmem writes at kij*36..kij*36+35.
  - inst[34]=1 throughout; done pulses once.
- ACC address check:
  - onij 0 reads A_pmem 0, 37, 74, 114, 151, 188, 228, 265, 302;
  - onij 15 reads 21, 58, 95, 135, 172, 209, 249, 286, 323;
  - out_idx runs 0..15 in order, one out_valid each.
- ofifo_valid held 0 for 50 cycles in OWAIT → inst stays IDLE_INST, no ofifo_rd; on valid=1, ORD starts next cycle.
- start pulsed again during EXEC → ignored: kij and counters unchanged, exactly one done at the end.
- reset asserted mid-EXEC of kij=4 → next cycle all outputs at reset values; a fresh start restarts at kij=0 with A_xmem=1024.
